// File: rtl/cdc_fifo_read_side.sv
// Read half of a dual-clock FIFO: synchronizes the write pointer into the read
// clock domain, derives empty, and presents a registered output word with backpressure.
module cdc_fifo_read_side #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] write_address_gray,
    input  logic [DATA_WIDTH-1:0]    memory_read_data,
    input  logic                     read_ready,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [ADDRESS_WIDTH-1:0] read_address_gray,
    output logic [DATA_WIDTH-1:0]    read_data,
    output logic                     read_valid,
    output logic                     empty
);

    function automatic logic [ADDRESS_WIDTH-1:0] gray_to_binary(input logic [ADDRESS_WIDTH-1:0] g);
        logic [ADDRESS_WIDTH-1:0] b;
        b[ADDRESS_WIDTH-1] = g[ADDRESS_WIDTH-1];
        for (int i = ADDRESS_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ADDRESS_WIDTH-1:0] binary_to_gray(input logic [ADDRESS_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [ADDRESS_WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [ADDRESS_WIDTH-1:0] r_read_address;
    logic [ADDRESS_WIDTH-1:0] r_read_address_gray;
    logic [DATA_WIDTH-1:0]    r_read_data;
    logic                     r_read_valid;

    logic [ADDRESS_WIDTH-1:0] w_wsync;
    logic [ADDRESS_WIDTH-1:0] w_next_address;
    logic                     w_empty;
    logic                     w_load;

    // The first stage samples the asynchronous Gray pointer directly; only one bit
    // moves per write increment, so a metastable capture resolves to old or new.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
        end else begin
            r_sync[0] <= write_address_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_wsync        = gray_to_binary(r_sync[SYNC_STAGES-1]);
    assign w_empty        = (r_read_address == w_wsync);
    assign w_next_address = r_read_address + 1'b1;
    assign w_load         = (!r_read_valid || read_ready) && !w_empty;

    // Loading and accepting may coincide, which keeps the output full every cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_read_address      <= '0;
            r_read_address_gray <= '0;
            r_read_data         <= '0;
            r_read_valid        <= 1'b0;
        end else if (w_load) begin
            r_read_data         <= memory_read_data;
            r_read_valid        <= 1'b1;
            r_read_address      <= w_next_address;
            r_read_address_gray <= binary_to_gray(w_next_address);
        end else if (r_read_valid && read_ready) begin
            r_read_valid        <= 1'b0;
        end
    end

    assign read_address      = r_read_address;
    assign read_address_gray = r_read_address_gray;
    assign read_data         = r_read_data;
    assign read_valid        = r_read_valid;
    assign empty             = w_empty;

endmodule

// File: tb/tb_cdc_fifo_read_side.sv
// Directed and randomized-CDC bench for cdc_fifo_read_side with a behavioural
// storage array and write-side pointer generator.
`timescale 1ns/1ps
module tb_cdc_fifo_read_side;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int N_RND = 200;
    localparam logic [3:0] GRAY_TAB [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                             4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    logic          clock = 1'b0;
    logic          wclk  = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] write_address_gray;
    logic [DW-1:0] memory_read_data;
    logic          read_ready = 1'b0;
    logic [AW-1:0] read_address;
    logic [AW-1:0] read_address_gray;
    logic [DW-1:0] read_data;
    logic          read_valid;
    logic          empty;

    logic [AW-1:0] wptr  = '0;
    logic [AW-1:0] rwbin = '0;
    logic          rnd_en = 1'b0;
    logic [DW-1:0] mem  [16];
    logic [DW-1:0] rmem [16];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] wdata;
    int            n_wr = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    assign write_address_gray = rnd_en ? GRAY_TAB[rwbin] : GRAY_TAB[wptr];
    assign memory_read_data   = rnd_en ? rmem[read_address] : mem[read_address];

    cdc_fifo_read_side #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clock             (clock),
        .reset             (reset),
        .write_address_gray(write_address_gray),
        .memory_read_data  (memory_read_data),
        .read_ready        (read_ready),
        .read_address      (read_address),
        .read_address_gray (read_address_gray),
        .read_data         (read_data),
        .read_valid        (read_valid),
        .empty             (empty)
    );

    always #5 clock = ~clock;
    always #3.7 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        wptr  = '0;
        rwbin = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Write domain for the randomized run: stores a word, then advances the Gray pointer.
    initial begin
        forever begin
            @(posedge wclk);
            if (rnd_en && !reset && n_wr < N_RND && $urandom_range(0, 1) == 1 &&
                (rwbin + 1'b1) != read_address) begin
                wdata       = DW'($urandom);
                rmem[rwbin] = wdata;
                exp_q.push_back(wdata);
                rwbin       = rwbin + 1'b1;
                n_wr++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t;
        int n_rd;
        logic [AW-1:0] prev_gray;
        logic [AW-1:0] exp_addr;

        for (int i = 0; i < 16; i++) begin
            mem[i]  = '0;
            rmem[i] = '0;
        end

        #1;
        chk("rst_valid", 32'(read_valid), 32'd0);
        chk("rst_addr", 32'(read_address), 32'd0);
        chk("rst_gray", 32'(read_address_gray), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        step();
        step();
        reset = 1'b0;

        // Bring read_address to 5 with a word held, then reset asynchronously.
        for (int i = 0; i < 6; i++) mem[i] = DW'(8'h10 + i);
        wptr = 4'd6;
        read_ready = 1'b1;
        t = 0;
        while (read_address != 4'd5 && t < 20) begin
            step();
            t++;
        end
        read_ready = 1'b0;
        chk("pre_rst_addr", 32'(read_address), 32'd5);
        chk("pre_rst_valid", 32'(read_valid), 32'd1);
        #2;
        reset = 1'b1;
        wptr  = '0;
        #1;
        chk("async_rst_valid", 32'(read_valid), 32'd0);
        chk("async_rst_addr", 32'(read_address), 32'd0);
        chk("async_rst_gray", 32'(read_address_gray), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        chk("async_rst_data", 32'(read_data), 32'd0);
        step();
        step();
        reset = 1'b0;
        #2;
        chk("post_rel_valid", 32'(read_valid), 32'd0);

        // Single word from slot 0: three-edge latency, then one accept.
        step();
        mem[0] = 8'hA5;
        read_ready = 1'b0;
        wptr = 4'd1;
        step();
        step();
        chk("lat_early_valid", 32'(read_valid), 32'd0);
        step();
        chk("single_valid", 32'(read_valid), 32'd1);
        chk("single_data", 32'(read_data), 32'hA5);
        chk("single_addr", 32'(read_address), 32'd1);
        chk("single_gray", 32'(read_address_gray), 32'd1);
        chk("single_empty", 32'(empty), 32'd1);
        read_ready = 1'b1;
        step();
        chk("single_drop", 32'(read_valid), 32'd0);
        chk("single_addr_hold", 32'(read_address), 32'd1);
        read_ready = 1'b0;

        // Backpressure with three entries, then drain with back-to-back accepts.
        do_reset();
        mem[0] = 8'h31;
        mem[1] = 8'h32;
        mem[2] = 8'h33;
        wptr = 4'd3;
        step();
        step();
        step();
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid", 32'(read_valid), 32'd1);
            chk("bp_data", 32'(read_data), 32'h31);
            chk("bp_addr", 32'(read_address), 32'd1);
            step();
        end
        read_ready = 1'b1;
        step();
        chk("drain1_data", 32'(read_data), 32'h32);
        chk("drain1_valid", 32'(read_valid), 32'd1);
        step();
        chk("drain2_data", 32'(read_data), 32'h33);
        chk("drain2_valid", 32'(read_valid), 32'd1);
        step();
        chk("drain_drop", 32'(read_valid), 32'd0);
        chk("drain_addr", 32'(read_address), 32'd3);

        // Streaming twenty words through the wrap with read_ready held high.
        do_reset();
        read_ready = 1'b1;
        prev_gray = '0;
        for (int n = 0; n <= 22; n++) begin
            if (n < 20) begin
                mem[n % 16] = DW'(8'h40 + n);
                wptr = AW'(n + 1);
            end
            step();
            if (n >= 2 && n <= 21) begin
                exp_addr = AW'((n - 1) % 16);
                chk("stream_valid", 32'(read_valid), 32'd1);
                chk("stream_data", 32'(read_data), 32'(8'h40 + n - 2));
                chk("stream_addr", 32'(read_address), 32'(exp_addr));
                chk("stream_gray", 32'(read_address_gray), 32'(GRAY_TAB[exp_addr]));
                chk("stream_hamming", 32'($countones(read_address_gray ^ prev_gray)), 32'd1);
                prev_gray = read_address_gray;
            end else if (n == 22) begin
                chk("stream_drop", 32'(read_valid), 32'd0);
            end
        end
        read_ready = 1'b0;

        // Randomized asynchronous write side against random backpressure.
        #2;
        reset  = 1'b1;
        wptr   = '0;
        rwbin  = '0;
        rnd_en = 1'b1;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        n_rd = 0;
        t = 0;
        while (n_rd < N_RND && t < 5000) begin
            read_ready = ($urandom_range(0, 3) != 0);
            if (read_valid && read_ready) begin
                chk("rnd_underflow", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("rnd_data", 32'(read_data), 32'(exp_q.pop_front()));
                n_rd++;
            end
            step();
            t++;
        end
        chk("rnd_count", 32'(n_rd), 32'(N_RND));
        read_ready = 1'b0;
        repeat (5) step();
        chk("rnd_final_valid", 32'(read_valid), 32'd0);
        chk("rnd_leftover", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_fifo_read_side.md
CDC_FIFO_READ_SIDE -- requirements
Module: cdc_fifo_read_side

Interface
- REQ-001 SHALL have parameter ADDRESS_WIDTH, default 4, giving the pointer width; FIFO depth is 2^ADDRESS_WIDTH slots and usable capacity is 2^ADDRESS_WIDTH-1 entries.
- REQ-002 SHALL have parameter DATA_WIDTH, default 8, giving the width of the FIFO word.
- REQ-003 SHALL have parameter SYNC_STAGES, default 2, minimum 2, giving the flop count of the write-pointer synchronizer.
- REQ-004 SHALL have one clock, `clock`, rising-edge, read domain; reset is asynchronous and active-high, named `reset`.
- REQ-005 Port list (name, direction, width, meaning), clock and reset first:
  - `clock`  in  1  read-domain clock.
  - `reset`  in  1  asynchronous active-high reset.
  - `write_address_gray`  in  ADDRESS_WIDTH  write pointer in Gray code, from the write domain; asynchronous to `clock`.
  - `memory_read_data`  in  DATA_WIDTH  combinational read data of the storage array at `read_address`.
  - `read_ready`  in  1  consumer accepts `read_data` this cycle.
  - `read_address`  out  ADDRESS_WIDTH  binary read pointer, driving the storage array read port.
  - `read_address_gray`  out  ADDRESS_WIDTH  registered Gray read pointer, sent to the write domain.
  - `read_data`  out  DATA_WIDTH  registered output word.
  - `read_valid`  out  1  `read_data` holds a valid word.
  - `empty`  out  1  no unread entry remains in storage; excludes the output register.

Function
- REQ-006 SHALL pass `write_address_gray` through a SYNC_STAGES-deep flop chain clocked by `clock`; no logic before the first flop.
- REQ-007 SHALL convert the last synchronizer stage from Gray to binary (wsync) using shared gray_to_binary logic.
- REQ-008 SHALL assert `empty` combinationally when `read_address` == wsync.
- REQ-009 Output register loads when (!`read_valid` | `read_ready`) & !`empty`:
  - `read_data` <= `memory_read_data`
  - `read_valid` <= 1
  - `read_address` <= `read_address` + 1, modulo 2^ADDRESS_WIDTH
- REQ-010 When `read_valid` & `read_ready` & `empty`, SHALL clear `read_valid` and hold `read_data` and `read_address`.
- REQ-011 When `read_valid` & !`read_ready`, SHALL hold `read_data`, `read_valid` and `read_address` unchanged, whatever `empty` is.
- REQ-012 Simultaneous accept and load (`read_valid` & `read_ready` & !`empty`) SHALL replace the word in the same cycle, with no bubble; sustained throughput is 1 word/cycle.
- REQ-013 SHALL update `read_address_gray` in the same clock edge as `read_address`, registered from binary_to_gray(next `read_address`); no combinational path from `read_address` to the output.
- REQ-014 SHALL wrap the pointer from 2^ADDRESS_WIDTH-1 to 0 with no special case; `read_address_gray` changes exactly one bit per increment, including at wrap.
- REQ-015 Latency: a write-pointer change stable at input before edge 0 SHALL give `read_valid`=1 after edge SYNC_STAGES+1 (3 cycles at default), provided the output register is free.
- REQ-016 `read_valid` SHALL never assert while `empty` was 1 in the loading cycle; no underflow is possible.

Reset
- REQ-017 On `reset` assertion, SHALL asynchronously clear:
  - all synchronizer flops to 0
  - `read_address` and `read_address_gray` to 0
  - `read_valid` and `read_data` to 0
- REQ-018 Outputs after reset SHALL be `empty`=1 (while `write_address_gray`=0) and `read_valid`=0.
- REQ-019 Reset mid-transfer SHALL discard the held word and stored entries; the first load after deassertion comes from slot 0.
- REQ-020 The first state change after reset deassertion SHALL occur no earlier than the first rising `clock` edge with `reset` low.

Verification
- REQ-021 Reset: assert `reset` with `read_valid`=1 and `read_address`=5 -> `read_valid`=0, `read_address`=0, `read_address_gray`=0, `empty`=1 immediately, before any clock edge.
- REQ-022 Single word: hold `read_ready`=0, set `write_address_gray`=4'b0001, `memory_read_data`=8'hA5 -> `read_valid`=1 and `read_data`=8'hA5 after 3 edges; `read_address`=1, `empty`=1; then `read_ready`=1 for one cycle -> `read_valid`=0.
- REQ-023 Backpressure: 3 entries available, `read_ready`=0 for 10 cycles -> `read_address`=1, and `read_data` is stable at the first word throughout.
- REQ-024 Streaming and wrap: write pointer advanced through all 16 codes, `read_ready`=1 -> one word per cycle, no bubbles; `read_address` goes 15 -> 0; `read_address_gray` goes 4'b1000 -> 4'b0000; every gray step has Hamming distance 1.
- REQ-025 Simultaneous accept and load: `read_valid`=1, `read_ready`=1, 2 entries pending -> a new word every cycle, `read_valid` never drops, then drops one cycle after the last accept.
- REQ-026 Random CDC: write pointer driven from an asynchronous clock with random gray increments, random `read_ready` -> read sequence equals write sequence, with no loss or duplication, and `read_valid` never asserts on an empty FIFO.
